// File: rtl/key_expansion.sv
// Iterative AES-128 key schedule: 128-bit key -> 11 round keys (round r at [r*128 +: 128]).
// Latency 10/ROUNDS_PER_CYCLE cycles from accepted start to finish; start ignored while busy.
// Optional per-round key stream (rk_valid/rk_index/rk_data) when KEYEXP_STREAM_EN is defined.
module key_expansion #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [127:0]  key,
    input  logic          start,
    output logic [1407:0] expanded_key,
    output logic          busy,
    output logic          finish
`ifdef KEYEXP_STREAM_EN
    ,
    output logic          rk_valid,
    output logic [3:0]    rk_index,
    output logic [127:0]  rk_data
`endif
);

    localparam int         RPC          = ROUNDS_PER_CYCLE;
    localparam logic [3:0] RPC4         = 4'(RPC);
    localparam logic [3:0] LAST_ROUND_Q = 4'(11 - RPC);

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_d;
    logic           accept;
    logic [3:0]     round_q;
    logic [7:0]     rcon_q;
    logic [7:0]     rcon_nx;
    logic [127:0]   key_q;
    logic [127:0]   last_rk;
    logic [127:0]   rk_q [1:10];
    logic [127:0]   nk [RPC];
    logic [127:0]   chain;
    logic [7:0]     rc;

    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        return SBOX[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // One round of the schedule: previous round key in, next round key out.
    function automatic logic [127:0] next_round(input logic [127:0] prev, input logic [7:0] rcon);
        logic [31:0] rot;
        logic [31:0] w0, w1, w2, w3;
        rot = {prev[23:0], prev[31:24]};
        w0  = prev[127:96] ^ {sub_byte(rot[31:24]) ^ rcon, sub_byte(rot[23:16]),
                              sub_byte(rot[15:8]), sub_byte(rot[7:0])};
        w1  = prev[95:64] ^ w0;
        w2  = prev[63:32] ^ w1;
        w3  = prev[31:0]  ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    always_comb begin
        state_d = state;
        accept  = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (round_q == LAST_ROUND_Q) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Chain RPC rounds combinationally from the most recently written round key.
    always_comb begin
        chain = last_rk;
        rc    = rcon_q;
        for (int j = 0; j < RPC; j++) begin
            chain = next_round(chain, rc);
            nk[j] = chain;
            rc    = xtime(rc);
        end
        rcon_nx = rc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_q   <= '0;
            last_rk <= '0;
            round_q <= 4'd0;
            rcon_q  <= 8'h01;
            busy    <= 1'b0;
            finish  <= 1'b0;
        end else begin
            busy   <= (state_d == RUN);
            finish <= (state_d == DONE);
            if (accept) begin
                key_q   <= key;
                last_rk <= key;
                round_q <= 4'd1;
                rcon_q  <= 8'h01;
            end else if (state == RUN) begin
                last_rk <= nk[RPC-1];
                round_q <= round_q + RPC4;
                rcon_q  <= rcon_nx;
            end
        end
    end

    assign expanded_key[127:0] = key_q;

    // Slot r is written on the single RUN edge whose batch covers it, at a fixed chain offset.
    for (genvar r = 1; r <= 10; r++) begin : g_slot
        localparam logic [3:0] WR_AT = 4'(((r - 1) / RPC) * RPC + 1);
        localparam int         OFF   = (r - 1) % RPC;

        always_ff @(posedge clk) begin
            if (rst) begin
                rk_q[r] <= '0;
            end else if (state == RUN && round_q == WR_AT) begin
                rk_q[r] <= nk[OFF];
            end
        end

        assign expanded_key[r*128 +: 128] = rk_q[r];
    end

`ifdef KEYEXP_STREAM_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rk_valid <= 1'b0;
            rk_index <= 4'd0;
            rk_data  <= '0;
        end else begin
            rk_valid <= 1'b0;
            if (accept) begin
                rk_valid <= 1'b1;
                rk_index <= 4'd0;
                rk_data  <= key;
            end else if (state == RUN) begin
                rk_valid <= 1'b1;
                rk_index <= round_q + RPC4 - 4'd1;
                rk_data  <= nk[RPC-1];
            end
        end
    end
`endif

endmodule

// File: tb/tb_key_expansion.sv
// Self-checking bench for key_expansion: FIPS-197 word-level model plus directed vectors.
module tb_key_expansion;

    localparam logic [127:0] K1    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K1_R1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] K1_RA = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] K0_R1 = 128'h62636363626363636263636362636363;
    localparam logic [127:0] K0_RA = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [127:0]  key = '0;
    logic          start1 = 1'b0;
    logic          startm = 1'b0;
    logic [1407:0] ek1, ek2, ek5, ek10;
    logic          busy1, busy2, busy5, busy10;
    logic          fin1, fin2, fin5, fin10;
    logic [1407:0] exp1 = '0;
    logic [1407:0] expm = '0;
    logic [7:0]    sbox_t [256];
    int            n_checks = 0;
    int            n_pass = 0;
`ifdef KEYEXP_STREAM_EN
    logic          v1;
    logic [3:0]    i1;
    logic [127:0]  d1;
    logic          vm [3];
    logic [3:0]    im [3];
    logic [127:0]  dm [3];
    int            stream_cnt = 0;
    int            last_idx = 0;
`endif

    always #5 clk = ~clk;

    key_expansion #(.ROUNDS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst(rst), .key(key), .start(start1),
        .expanded_key(ek1), .busy(busy1), .finish(fin1)
`ifdef KEYEXP_STREAM_EN
        , .rk_valid(v1), .rk_index(i1), .rk_data(d1)
`endif
    );
    key_expansion #(.ROUNDS_PER_CYCLE(2)) dut2 (
        .clk(clk), .rst(rst), .key(key), .start(startm),
        .expanded_key(ek2), .busy(busy2), .finish(fin2)
`ifdef KEYEXP_STREAM_EN
        , .rk_valid(vm[0]), .rk_index(im[0]), .rk_data(dm[0])
`endif
    );
    key_expansion #(.ROUNDS_PER_CYCLE(5)) dut5 (
        .clk(clk), .rst(rst), .key(key), .start(startm),
        .expanded_key(ek5), .busy(busy5), .finish(fin5)
`ifdef KEYEXP_STREAM_EN
        , .rk_valid(vm[1]), .rk_index(im[1]), .rk_data(dm[1])
`endif
    );
    key_expansion #(.ROUNDS_PER_CYCLE(10)) dut10 (
        .clk(clk), .rst(rst), .key(key), .start(startm),
        .expanded_key(ek10), .busy(busy10), .finish(fin10)
`ifdef KEYEXP_STREAM_EN
        , .rk_valid(vm[2]), .rk_index(im[2]), .rk_data(dm[2])
`endif
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int k = 0; k < 8; k++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return 8'((x << n) | (x >> (8 - n)));
    endfunction

    // S-box from its definition: multiplicative inverse in GF(2^8) followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [1407:0] expand(input logic [127:0] k);
        logic [31:0]   w [44];
        logic [31:0]   t;
        logic [7:0]    rcv = 8'h01;
        logic [1407:0] res = '0;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
                t = t ^ {rcv, 24'h0};
                rcv = gmul(rcv, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 44; i++) res[(i/4)*128 + 96 - 32*(i%4) +: 32] = w[i];
        return res;
    endfunction

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, want);
    endtask

    task automatic chk_ek(input string name, input logic [1407:0] got, input logic [1407:0] want);
        int bad = -1;
        n_checks++;
        for (int s = 10; s >= 0; s--)
            if (got[s*128 +: 128] !== want[s*128 +: 128]) bad = s;
        if (bad < 0) n_pass++;
        else $display("FAIL %s: slot %0d got %h expected %h", name, bad,
                      got[bad*128 +: 128], want[bad*128 +: 128]);
    endtask

    // Whenever a DUT reports finish its expanded key must match the model of its captured key.
    always @(negedge clk) begin
        if (!rst) begin
            if (fin1)  chk_ek("ek_rpc1", ek1, exp1);
            if (fin2)  chk_ek("ek_rpc2", ek2, expm);
            if (fin5)  chk_ek("ek_rpc5", ek5, expm);
            if (fin10) chk_ek("ek_rpc10", ek10, expm);
            chk("busy_fin_exclusive", {127'b0, busy1 & fin1}, 128'd0);
`ifdef KEYEXP_STREAM_EN
            if (v1) begin
                stream_cnt++;
                chk("rk_index_seq", {124'b0, i1},
                    (i1 == 4'd0) ? 128'd0 : 128'(last_idx + 1));
                chk("rk_data", d1, exp1[i1*128 +: 128]);
                last_idx = int'(i1);
            end
`endif
        end
    end

    task automatic do_start(input logic [127:0] k, input logic hold);
        @(posedge clk); #1;
        key = k;
        start1 = 1'b1;
        @(posedge clk); #1;
        exp1 = expand(k);
        if (!hold) start1 = 1'b0;
        chk("finish_drops_at_start", {127'b0, fin1}, 128'd0);
        chk("busy_at_start", {127'b0, busy1}, 128'd1);
    endtask

    task automatic wait_fin(input int lat, input logic scramble, input string name);
        int n = 0;
        int bcnt = 0;
        if (busy1) bcnt++;
        while (!fin1 && n < 20) begin
            if (scramble) key = ~key ^ 128'h5a5a_0f0f_1234_5678_9abc_def0_c3c3_a5a5;
            @(posedge clk); #1;
            n++;
            if (busy1 && !fin1) bcnt++;
        end
        chk({name, "_latency"}, 128'(n), 128'(lat));
        chk({name, "_busy_cycles"}, 128'(bcnt), 128'(lat));
    endtask

    initial begin
        logic [1407:0] m;
        int f2, f5, f10;
        build_sbox();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk_ek("reset_ek", ek1, '0);
        chk("reset_busy", {127'b0, busy1}, 128'd0);
        chk("reset_finish", {127'b0, fin1}, 128'd0);
        chk_ek("reset_ek_rpc10", ek10, '0);
`ifdef KEYEXP_STREAM_EN
        chk("reset_rk", {v1, i1, d1[122:0]}, 128'd0);
`endif

        m = expand(K1);
        chk("model_k1_r1", m[128 +: 128], K1_R1);
        chk("model_k1_r10", m[1280 +: 128], K1_RA);
        m = expand(128'd0);
        chk("model_k0_r1", m[128 +: 128], K0_R1);
        chk("model_k0_r10", m[1280 +: 128], K0_RA);

        // Test 1: reference key, single-cycle start.
`ifdef KEYEXP_STREAM_EN
        stream_cnt = 0;
`endif
        do_start(K1, 1'b0);
        wait_fin(10, 1'b0, "t1");
        chk("t1_round0", ek1[127:0], K1);
        chk("t1_round1", ek1[128 +: 128], K1_R1);
        chk("t1_round10", ek1[1280 +: 128], K1_RA);
`ifdef KEYEXP_STREAM_EN
        @(negedge clk); #1;
        chk("stream_pulses", 128'(stream_cnt), 128'd11);
        chk("stream_last_index", 128'(last_idx), 128'd10);
`endif

        // Wider rounds-per-cycle builds on the same key.
        @(posedge clk); #1;
        key = K1;
        startm = 1'b1;
        @(posedge clk); #1;
        startm = 1'b0;
        expm = expand(K1);
        f2 = -1; f5 = -1; f10 = -1;
        for (int n = 0; n < 12; n++) begin
            if (fin2 && f2 < 0) f2 = n;
            if (fin5 && f5 < 0) f5 = n;
            if (fin10 && f10 < 0) f10 = n;
            @(posedge clk); #1;
        end
        chk("rpc2_latency", 128'(f2), 128'd5);
        chk("rpc5_latency", 128'(f5), 128'd2);
        chk("rpc10_latency", 128'(f10), 128'd1);
        chk_ek("rpc2_vs_rpc1", ek2, ek1);
        chk("rpc10_round10", ek10[1280 +: 128], K1_RA);

        // Test 5: restart from DONE with the all-zero key.
        do_start(128'd0, 1'b0);
        wait_fin(10, 1'b0, "t5");
        chk("t5_round1", ek1[128 +: 128], K0_R1);
        chk("t5_round10", ek1[1280 +: 128], K0_RA);

        // Test 3: start held and key scrambled while running.
        do_start(K1, 1'b1);
        wait_fin(10, 1'b1, "t3");
        start1 = 1'b0;
        chk("t3_round1", ek1[128 +: 128], K1_R1);
        chk("t3_round10", ek1[1280 +: 128], K1_RA);
        for (int n = 0; n < 4; n++) begin
            @(posedge clk); #1;
            chk("t3_finish_held", {127'b0, fin1}, 128'd1);
            chk("t3_busy_low", {127'b0, busy1}, 128'd0);
        end

        // Test 4: reset on the fifth RUN edge, then a fresh expansion.
        do_start(K1, 1'b0);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_ek("t4_ek_cleared", ek1, '0);
        chk("t4_busy", {127'b0, busy1}, 128'd0);
        chk("t4_finish", {127'b0, fin1}, 128'd0);
        chk_ek("t4_rpc2_cleared", ek2, '0);
        do_start(K1, 1'b0);
        wait_fin(10, 1'b0, "t4b");
        chk("t4b_round10", ek1[1280 +: 128], K1_RA);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
